ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 183 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M-style multiply/divide unit: restoring divide, shift-add multiply.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational one.
module ex_muldiv #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         funct3_i,
   input  logic [XLEN-1:0]    op1_i,
   input  logic [XLEN-1:0]    op2_i,
   input  logic [RADDR_W-1:0] rd_addr_i,
   input  logic               flush_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [XLEN-1:0]    result_o,
   output logic [RADDR_W-1:0] rd_addr_o
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_f3;
   logic               r_neg1;
   logic               r_neg2;
   logic [RADDR_W-1:0] r_rd;
   logic [XLEN-1:0]    r_a;
   logic [XLEN-1:0]    r_hi;
   logic [XLEN-1:0]    r_lo;
   logic [XLEN-1:0]    r_result;
   logic [RADDR_W-1:0] r_rd_out;

   logic               w_sgn1;
   logic               w_sgn2;
   logic               w_neg1;
   logic               w_neg2;
   logic [XLEN-1:0]    w_mag1;
   logic [XLEN-1:0]    w_mag2;
   logic               w_div0;
   logic               w_ovf;
   logic [XLEN-1:0]    w_special;
   logic [XLEN:0]      w_shift;
   logic [XLEN:0]      w_diff;
   logic [XLEN:0]      w_sum;
   logic [XLEN-1:0]    w_hi_nx;
   logic [XLEN-1:0]    w_lo_nx;
   logic [2*XLEN-1:0]  w_prod;
   logic [2*XLEN-1:0]  w_prod_s;
   logic [XLEN-1:0]    w_quo;
   logic [XLEN-1:0]    w_rem;
   logic [XLEN-1:0]    w_calc_res;

   // Operand decode at issue: sign handling and the two short-circuit divide cases
   always_comb begin
      w_sgn1 = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
               (funct3_i == 3'b100) || (funct3_i == 3'b110);
      w_sgn2 = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
      w_neg1 = w_sgn1 & op1_i[XLEN-1];
      w_neg2 = w_sgn2 & op2_i[XLEN-1];
      w_mag1 = w_neg1 ? (~op1_i + XLEN'(1)) : op1_i;
      w_mag2 = w_neg2 ? (~op2_i + XLEN'(1)) : op2_i;
      w_div0 = funct3_i[2] && (op2_i == '0);
      w_ovf  = funct3_i[2] && !funct3_i[0] && (op2_i == '1) &&
               (op1_i == {1'b1, {(XLEN-1){1'b0}}});
      if (w_div0)
         w_special = funct3_i[1] ? op1_i : '1;
      else
         w_special = funct3_i[1] ? '0 : op1_i;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fprod;
   logic [2*XLEN-1:0] w_fprod_s;
   logic [XLEN-1:0]   w_fast_res;

   always_comb begin
      w_fprod    = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
      w_fprod_s  = (w_neg1 ^ w_neg2) ? (~w_fprod + (2*XLEN)'(1)) : w_fprod;
      w_fast_res = (funct3_i == 3'b000) ? w_fprod_s[XLEN-1:0] : w_fprod_s[2*XLEN-1:XLEN];
   end
`endif

   // {r_hi, r_lo} is one shift register: remainder/quotient for divide, product/multiplier for multiply
   always_comb begin
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_a};
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      if (r_f3[2]) begin
         if (!w_diff[XLEN]) begin
            w_hi_nx = w_diff[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
         end else begin
            w_hi_nx = w_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         w_hi_nx = w_sum[XLEN:1];
         w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
      end
      w_prod   = {w_hi_nx, w_lo_nx};
      w_prod_s = (r_neg1 ^ r_neg2) ? (~w_prod + (2*XLEN)'(1)) : w_prod;
      w_quo    = (r_neg1 ^ r_neg2) ? (~w_lo_nx + XLEN'(1)) : w_lo_nx;
      w_rem    = r_neg1 ? (~w_hi_nx + XLEN'(1)) : w_hi_nx;
      case (r_f3)
         3'b000:          w_calc_res = w_prod_s[XLEN-1:0];
         3'b100, 3'b101:  w_calc_res = w_quo;
         3'b110, 3'b111:  w_calc_res = w_rem;
         default:         w_calc_res = w_prod_s[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_f3     <= '0;
         r_neg1   <= 1'b0;
         r_neg2   <= 1'b0;
         r_rd     <= '0;
         r_a      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else if (flush_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_f3   <= funct3_i;
                  r_neg1 <= w_neg1;
                  r_neg2 <= w_neg2;
                  r_rd   <= rd_addr_i;
                  r_cnt  <= '0;
                  r_hi   <= '0;
                  r_a    <= funct3_i[2] ? w_mag2 : w_mag1;
                  r_lo   <= funct3_i[2] ? w_mag1 : w_mag2;
                  if (w_div0 || w_ovf) begin
                     r_result <= w_special;
                     r_rd_out <= rd_addr_i;
                     r_state  <= S_DONE;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!funct3_i[2]) begin
                     r_result <= w_fast_res;
                     r_rd_out <= rd_addr_i;
                     r_state  <= S_DONE;
                  end
`endif
                  else begin
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_hi  <= w_hi_nx;
               r_lo  <= w_lo_nx;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(XLEN-1)) begin
                  r_cnt    <= '0;
                  r_result <= w_calc_res;
                  r_rd_out <= r_rd;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o    = (r_state != S_IDLE);
   assign done_o    = (r_state == S_DONE);
   assign result_o  = r_result;
   assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv at XLEN=32; multiply latency follows MULDIV_FAST_MUL_EN.
module tb_ex_muldiv;

   localparam int XLEN = 32;
   localparam int RW   = 5;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MLAT = 1;
`else
   localparam int MLAT = 33;
`endif
   localparam int DLAT = 33;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [RW-1:0]   rd_addr_i;
   logic            flush_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic [RW-1:0]   rd_addr_o;

   int n_vec  = 0;
   int n_miss = 0;

   ex_muldiv #(.XLEN(XLEN), .RADDR_W(RW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .funct3_i  (funct3_i),
      .op1_i     (op1_i),
      .op2_i     (op2_i),
      .rd_addr_i (rd_addr_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .rd_addr_o (rd_addr_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue in the current cycle (cycle 0), then count cycles until done_o
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
      int lat;
      funct3_i  = f;
      op1_i     = a;
      op2_i     = b;
      rd_addr_i = rd;
      start_i   = 1'b1;
      tick();
      start_i   = 1'b0;
      op1_i     = ~a;
      op2_i     = ~b;
      rd_addr_i = ~rd;
      lat = 1;
      while (!done_o && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " result"}, 64'(result_o), 64'(exp));
      chk({tag, " rd"}, 64'(rd_addr_o), 64'(rd));
      tick();
      chk({tag, " done drop"}, 64'(done_o), 64'd0);
      chk({tag, " idle"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      int pulses;
      int done_cyc;
      logic [31:0] res_at;
      logic [4:0]  rd_at;

      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      funct3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
      tick();
      tick();
      chk("reset busy", 64'(busy_o), 64'd0);
      chk("reset done", 64'(done_o), 64'd0);
      chk("reset result", 64'(result_o), 64'd0);
      chk("reset rd", 64'(rd_addr_o), 64'd0);
      rst = 1'b0;
      tick();

      do_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,        5'd3,  32'hFFFF_FFFD, DLAT);
      do_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,        5'd4,  32'hFFFF_FFFF, DLAT);
      do_op("DIVU 100/0",      3'b101, 32'd100,       32'd0,        5'd5,  32'hFFFF_FFFF, 1);
      do_op("REMU 100/0",      3'b111, 32'd100,       32'd0,        5'd6,  32'd100,       1);
      do_op("DIV -8/0",        3'b100, 32'hFFFF_FFF8, 32'd0,        5'd7,  32'hFFFF_FFFF, 1);
      do_op("REM -8/0",        3'b110, 32'hFFFF_FFF8, 32'd0,        5'd8,  32'hFFFF_FFF8, 1);
      do_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1);
      do_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1);
      do_op("DIVU minneg/-1",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         DLAT);
      do_op("DIVU 100/7",      3'b101, 32'd100,       32'd7,        5'd12, 32'd14,        DLAT);
      do_op("REMU 100/7",      3'b111, 32'd100,       32'd7,        5'd13, 32'd2,         DLAT);
      do_op("DIV 7/-2",        3'b100, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, DLAT);
      do_op("REM 7/-2",        3'b110, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         DLAT);
      do_op("REM -7/-2",       3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFF, DLAT);
      do_op("MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'd0,         MLAT);
      do_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFE, MLAT);
      do_op("MUL -1*-1",       3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'd1,         MLAT);
      do_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFF, MLAT);
      do_op("MUL 12345*678",   3'b000, 32'd12345,     32'd678,      5'd21, 32'd8369910,   MLAT);
      do_op("MUL -3*5",        3'b000, 32'hFFFF_FFFD, 32'd5,        5'd22, 32'hFFFF_FFF1, MLAT);
      do_op("MULH -3*5",       3'b001, 32'hFFFF_FFFD, 32'd5,        5'd23, 32'hFFFF_FFFF, MLAT);
      do_op("MULHSU minneg*2", 3'b010, 32'h8000_0000, 32'd2,        5'd24, 32'hFFFF_FFFF, MLAT);
      do_op("MULHU 2^31*4",    3'b011, 32'h8000_0000, 32'd4,        5'd25, 32'd2,         MLAT);

      // Flush in cycle 10 together with a start; restart in cycle 11
      funct3_i = 3'b101; op1_i = 32'd1000; op2_i = 32'd3; rd_addr_i = 5'd1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      pulses = 0;
      for (int c = 1; c < 10; c++) begin
         if (done_o) pulses++;
         tick();
      end
      flush_i = 1'b1; start_i = 1'b1;
      funct3_i = 3'b101; op1_i = 32'd9; op2_i = 32'd3; rd_addr_i = 5'd2;
      tick();
      flush_i = 1'b0; start_i = 1'b0;
      chk("flush idle", 64'(busy_o), 64'd0);
      chk("flush no done", 64'(done_o + pulses), 64'd0);
      do_op("flush restart", 3'b101, 32'd50, 32'd5, 5'd26, 32'd10, DLAT);

      // Reset in cycle 5 of a DIV
      funct3_i = 3'b100; op1_i = 32'hFFFF_FF9C; op2_i = 32'd3; rd_addr_i = 5'd27;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      chk("pre-reset busy", 64'(busy_o), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst busy", 64'(busy_o), 64'd0);
      chk("midrst done", 64'(done_o), 64'd0);
      chk("midrst result", 64'(result_o), 64'd0);
      chk("midrst rd", 64'(rd_addr_o), 64'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (done_o) pulses++;
         tick();
      end
      chk("midrst pulses", 64'(pulses), 64'd0);

      // Start pulsed in cycle 3 of a DIV is ignored
      funct3_i = 3'b100; op1_i = 32'hFFFF_FF9C; op2_i = 32'd3; rd_addr_i = 5'd28;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      pulses = 0; done_cyc = 0; res_at = '0; rd_at = '0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 3) begin
            funct3_i = 3'b101; op1_i = 32'd9; op2_i = 32'd3; rd_addr_i = 5'd29;
            start_i = 1'b1;
         end
         if (done_o) begin
            pulses++;
            done_cyc = c;
            res_at = result_o;
            rd_at = rd_addr_o;
         end
         tick();
         start_i = 1'b0;
      end
      chk("ign pulses", 64'(pulses), 64'd1);
      chk("ign latency", 64'(done_cyc), 64'd33);
      chk("ign result", 64'(res_at), 64'hFFFF_FFDF);
      chk("ign rd", 64'(rd_at), 64'd28);

      // Start held during the DONE cycle is ignored
      funct3_i = 3'b101; op1_i = 32'd20; op2_i = 32'd4; rd_addr_i = 5'd30;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c < 33 && !done_o; c++) tick();
      chk("done-cycle done", 64'(done_o), 64'd1);
      chk("done-cycle result", 64'(result_o), 64'd5);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("done-cycle start ignored", 64'(busy_o), 64'd0);
      tick();
      chk("done-cycle still idle", 64'(busy_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
